mesh_edge_port: RTL and testbench

MESH_EDGE_PORT -- requirements
Module: mesh_edge_port

---
 rtl/mesh_edge_port.sv | 73 +++++++
 tb/tb_mesh_edge_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_edge_port.sv
// mesh_edge_port: host<->mesh boundary adapter with registered TX/RX FIFOs and saturating flit counters
module mesh_edge_port #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] host_tx_data,
  input  logic                  host_tx_valid,
  output logic                  host_tx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vout,
  input  logic                  rin,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  vin,
  output logic                  rout,
  output logic [DATA_WIDTH-1:0] host_rx_data,
  output logic                  host_rx_valid,
  input  logic                  host_rx_ready,
  output logic [CNT_WIDTH-1:0]  tx_cnt,
  output logic [CNT_WIDTH-1:0]  rx_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_occ, rx_occ;
  logic tx_push, tx_pop, rx_push, rx_pop;
  assign host_tx_ready = tx_occ != FULL;
  assign vout = tx_occ != '0;
  assign dout = tx_mem[tx_rp];
  assign rout = rx_occ != FULL;
  assign host_rx_valid = rx_occ != '0;
  assign host_rx_data = rx_mem[rx_rp];
  assign tx_push = host_tx_valid && host_tx_ready;
  assign tx_pop = vout && rin;
  assign rx_push = vin && rout;
  assign rx_pop = host_rx_valid && host_rx_ready;
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= host_tx_data;
    if (rx_push) rx_mem[rx_wp] <= din;
  end
  // flush clears pointers like reset but leaves the counters alone
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_occ <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      rx_occ <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      tx_occ <= tx_occ + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      rx_occ <= rx_occ + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else if (!flush) begin
      if (tx_pop && tx_cnt != '1) tx_cnt <= tx_cnt + CNT_WIDTH'(1);
      if (rx_pop && rx_cnt != '1) rx_cnt <= rx_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_mesh_edge_port.sv
// tb_mesh_edge_port: queue-based reference model, per-cycle compare, directed and random stimulus
module tb_mesh_edge_port;
  localparam int DW = 32;
  localparam int D = 4;
  localparam int CMAX = 65535;
  logic clk = 0;
  logic rst = 1, flush = 0;
  logic [DW-1:0] host_tx_data = '0, din = '0;
  logic host_tx_valid = 0, rin = 0, vin = 0, host_rx_ready = 0;
  logic host_tx_ready, vout, rout, host_rx_valid;
  logic [DW-1:0] dout, host_rx_data;
  logic [15:0] tx_cnt, rx_cnt;
  logic s_rst = 1, s_valid = 0;
  logic [7:0] s_data = '0;
  logic s_ready, s_vout, s_rout, s_rxv;
  logic [7:0] s_dout, s_rxd;
  logic [2:0] s_tx_cnt, s_rx_cnt;
  int total = 0, bad = 0;
  bit chk_on = 0;
  logic [DW-1:0] txq[$], rxq[$];
  int tc = 0, rc = 0;

  always #5 clk = ~clk;

  mesh_edge_port dut (
    .clk(clk), .rst(rst), .flush(flush),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .dout(dout), .vout(vout), .rin(rin),
    .din(din), .vin(vin), .rout(rout),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  mesh_edge_port #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(3)) sat (
    .clk(clk), .rst(s_rst), .flush(1'b0),
    .host_tx_data(s_data), .host_tx_valid(s_valid), .host_tx_ready(s_ready),
    .dout(s_dout), .vout(s_vout), .rin(1'b1),
    .din(8'h00), .vin(1'b0), .rout(s_rout),
    .host_rx_data(s_rxd), .host_rx_valid(s_rxv), .host_rx_ready(1'b0),
    .tx_cnt(s_tx_cnt), .rx_cnt(s_rx_cnt)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFOs as queues, transfers decided from pre-edge occupancy
  initial forever begin
    @(posedge clk);
    if (rst) begin
      txq.delete();
      rxq.delete();
      tc = 0;
      rc = 0;
    end else if (flush) begin
      txq.delete();
      rxq.delete();
    end else begin
      bit tpop, tpush, rpop, rpush;
      tpop = txq.size() > 0 && rin;
      tpush = host_tx_valid && txq.size() < D;
      rpop = rxq.size() > 0 && host_rx_ready;
      rpush = vin && rxq.size() < D;
      if (tpop) begin
        void'(txq.pop_front());
        if (tc < CMAX) tc++;
      end
      if (tpush) txq.push_back(host_tx_data);
      if (rpop) begin
        void'(rxq.pop_front());
        if (rc < CMAX) rc++;
      end
      if (rpush) rxq.push_back(din);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("host_tx_ready", 64'(host_tx_ready), 64'(txq.size() < D));
      chk("vout", 64'(vout), 64'(txq.size() > 0));
      if (txq.size() > 0) chk("dout", 64'(dout), 64'(txq[0]));
      chk("rout", 64'(rout), 64'(rxq.size() < D));
      chk("host_rx_valid", 64'(host_rx_valid), 64'(rxq.size() > 0));
      if (rxq.size() > 0) chk("host_rx_data", 64'(host_rx_data), 64'(rxq[0]));
      chk("tx_cnt", 64'(tx_cnt), 64'(tc));
      chk("rx_cnt", 64'(rx_cnt), 64'(rc));
    end
  end

  initial begin
    tick();
    tick();
    rst = 0;
    chk_on = 1;
    chk("rst host_tx_ready", 64'(host_tx_ready), 64'(1));
    chk("rst vout", 64'(vout), 64'(0));
    chk("rst rout", 64'(rout), 64'(1));
    chk("rst host_rx_valid", 64'(host_rx_valid), 64'(0));
    chk("rst tx_cnt", 64'(tx_cnt), 64'(0));
    chk("rst rx_cnt", 64'(rx_cnt), 64'(0));

    rin = 1;
    host_tx_data = 32'hA5A5_0001;
    host_tx_valid = 1;
    tick();
    host_tx_valid = 0;
    chk("basic vout", 64'(vout), 64'(1));
    chk("basic dout", 64'(dout), 64'h0000_0000_A5A5_0001);
    tick();
    chk("basic vout after", 64'(vout), 64'(0));
    chk("basic tx_cnt", 64'(tx_cnt), 64'(1));

    rin = 0;
    for (int i = 0; i < 5; i++) begin
      host_tx_data = 32'hB000_0000 + 32'(i);
      host_tx_valid = 1;
      tick();
      if (i == 3) chk("bp ready after 4", 64'(host_tx_ready), 64'(0));
    end
    host_tx_valid = 0;
    rin = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp vout", 64'(vout), 64'(1));
      chk("bp dout", 64'(dout), 64'(32'hB000_0000 + 32'(i)));
      tick();
    end
    chk("bp drained", 64'(vout), 64'(0));
    chk("bp tx_cnt", 64'(tx_cnt), 64'(5));

    for (int i = 0; i < 6; i++) begin
      din = 32'hC000_0000 + 32'(i);
      vin = 1;
      tick();
      if (i == 3) chk("rx rout after 4", 64'(rout), 64'(0));
    end
    vin = 0;
    host_rx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("rx valid", 64'(host_rx_valid), 64'(1));
      chk("rx data", 64'(host_rx_data), 64'(32'hC000_0000 + 32'(i)));
      tick();
    end
    chk("rx drained", 64'(host_rx_valid), 64'(0));
    chk("rx rx_cnt", 64'(rx_cnt), 64'(4));
    host_rx_ready = 0;

    rin = 0;
    for (int i = 0; i < 2; i++) begin
      host_tx_data = 32'hD000_0000 + 32'(i);
      host_tx_valid = 1;
      tick();
    end
    rin = 1;
    for (int i = 0; i < 10; i++) begin
      host_tx_data = 32'hD000_0002 + 32'(i);
      chk("pp dout", 64'(dout), 64'(32'hD000_0000 + 32'(i)));
      chk("pp ready", 64'(host_tx_ready), 64'(1));
      tick();
    end
    host_tx_valid = 0;
    for (int i = 10; i < 12; i++) begin
      chk("pp tail", 64'(dout), 64'(32'hD000_0000 + 32'(i)));
      tick();
    end
    chk("pp empty", 64'(vout), 64'(0));
    chk("pp tx_cnt", 64'(tx_cnt), 64'(17));

    rin = 0;
    for (int i = 0; i < 3; i++) begin
      host_tx_data = 32'hE000_0000 + 32'(i);
      host_tx_valid = 1;
      din = 32'hF000_0000 + 32'(i);
      vin = 1;
      tick();
    end
    host_tx_valid = 0;
    vin = 0;
    chk("fl pre vout", 64'(vout), 64'(1));
    chk("fl pre rxv", 64'(host_rx_valid), 64'(1));
    flush = 1;
    tick();
    flush = 0;
    chk("fl vout", 64'(vout), 64'(0));
    chk("fl rxv", 64'(host_rx_valid), 64'(0));
    chk("fl tx_cnt", 64'(tx_cnt), 64'(17));
    chk("fl rx_cnt", 64'(rx_cnt), 64'(4));
    host_tx_data = 32'h1234_5678;
    host_tx_valid = 1;
    tick();
    rin = 1;
    flush = 1;
    tick();
    flush = 0;
    host_tx_valid = 0;
    chk("fl xfer vout", 64'(vout), 64'(0));
    chk("fl xfer tx_cnt", 64'(tx_cnt), 64'(17));
    rin = 0;
    host_tx_valid = 1;
    tick();
    tick();
    host_tx_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("rst vout", 64'(vout), 64'(0));
    chk("rst2 tx_cnt", 64'(tx_cnt), 64'(0));
    chk("rst2 rx_cnt", 64'(rx_cnt), 64'(0));

    for (int i = 0; i < 3000; i++) begin
      host_tx_data = $urandom;
      host_tx_valid = ($urandom_range(0, 3) != 0);
      rin = ($urandom_range(0, 2) != 0);
      din = $urandom;
      vin = ($urandom_range(0, 3) != 0);
      host_rx_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    flush = 0;

    tick();
    s_rst = 0;
    for (int i = 0; i < 9; i++) begin
      s_data = 8'(i);
      s_valid = 1;
      tick();
    end
    s_valid = 0;
    tick();
    tick();
    chk("sat vout", 64'(s_vout), 64'(0));
    chk("sat tx_cnt", 64'(s_tx_cnt), 64'(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
